// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Two-master arbiter/sequencer in front of a single-port RAM.
//            m0 = instruction fetch (read-only), m1 = load/store (read/write
//            with byte enables). One transaction in flight: the winner's
//            request is latched, driven through the RAM valid/ready
//            handshake, read data is awaited, and a registered one-cycle
//            completion pulse is returned to the owning master.
// Options  : RAM_ARB_TIMEOUT_EN - bound the read-data wait to TIMEOUT_CYCLES
//            cycles; on expiry complete with data 0 and bus_err_out=1.
//            Undefined: wait forever, bus_err_out tied low.
// Ports    : clk, rst (async, active-low)
//            m0_req_in/m0_addr_in -> m0_grant_out, m0_rdata_valid_out, m0_rdata_out
//            m1_req_in/m1_addr_in/m1_wdata_in/m1_write_en_in/m1_byte_en_in
//                     -> m1_grant_out, m1_done_out, m1_rdata_out
//            bus_err_out
//            ram_addr_out, ram_write_data_out, ram_read_en_out,
//            ram_write_en_out, ram_write_byte_en_out, ram_valid_out
//            ram_ready_in, ram_rdata_valid_in, ram_rdata_in
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_in,
  input  logic [ADDR_W-1:0] m0_addr_in,
  output logic              m0_grant_out,
  output logic              m0_rdata_valid_out,
  output logic [DATA_W-1:0] m0_rdata_out,
  input  logic              m1_req_in,
  input  logic [ADDR_W-1:0] m1_addr_in,
  input  logic [DATA_W-1:0] m1_wdata_in,
  input  logic              m1_write_en_in,
  input  logic [3:0]        m1_byte_en_in,
  output logic              m1_grant_out,
  output logic              m1_done_out,
  output logic [DATA_W-1:0] m1_rdata_out,
  output logic              bus_err_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [DATA_W-1:0] ram_write_data_out,
  output logic              ram_read_en_out,
  output logic              ram_write_en_out,
  output logic [3:0]        ram_write_byte_en_out,
  output logic              ram_valid_out,
  input  logic              ram_ready_in,
  input  logic              ram_rdata_valid_in,
  input  logic [DATA_W-1:0] ram_rdata_in
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last_grant;  // 1: m1 won the most recent arbitration
  logic        r_owner;       // 1: m1 owns the transaction in flight
  logic        w_any_req;
  logic        w_pick_m1;
  logic        w_timeout;
  logic [DATA_W-1:0] w_fin_data;

  assign w_any_req = m0_req_in | m1_req_in;
  // Lone requester wins; on a tie the master that did not win last time wins.
  assign w_pick_m1 = m1_req_in & (~m0_req_in | ~r_last_grant);
  // A timed-out read completes with zero data.
  assign w_fin_data = ram_rdata_valid_in ? ram_rdata_in : '0;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int C_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [C_CNT_W-1:0] r_wait_cnt;
  logic               r_bus_err;

  // Real read data arriving on the final wait cycle still wins.
  assign w_timeout   = (r_state == S_WAIT_RD) & ~ram_rdata_valid_in &
                       (r_wait_cnt == C_CNT_LAST);
  assign bus_err_out = r_bus_err;
`else
  logic w_unused_timeout_cfg;

  // Without the timeout option the wait is unbounded; the parameter only
  // keeps the interface identical between builds.
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign w_timeout            = 1'b0;
  assign bus_err_out          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state               <= S_IDLE;
      r_last_grant          <= 1'b1;
      r_owner               <= 1'b0;
      m0_grant_out          <= 1'b0;
      m0_rdata_valid_out    <= 1'b0;
      m0_rdata_out          <= '0;
      m1_grant_out          <= 1'b0;
      m1_done_out           <= 1'b0;
      m1_rdata_out          <= '0;
      ram_addr_out          <= '0;
      ram_write_data_out    <= '0;
      ram_read_en_out       <= 1'b0;
      ram_write_en_out      <= 1'b0;
      ram_write_byte_en_out <= 4'b0000;
      ram_valid_out         <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
      r_wait_cnt            <= '0;
      r_bus_err             <= 1'b0;
`endif
    end else begin
      // Grant and completion outputs are single-cycle pulses.
      m0_grant_out       <= 1'b0;
      m1_grant_out       <= 1'b0;
      m0_rdata_valid_out <= 1'b0;
      m1_done_out        <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
      r_bus_err          <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner       <= w_pick_m1;
            r_last_grant  <= w_pick_m1;
            m0_grant_out  <= ~w_pick_m1;
            m1_grant_out  <= w_pick_m1;
            ram_valid_out <= 1'b1;
            r_state       <= S_ISSUE;
            if (w_pick_m1) begin
              ram_addr_out          <= m1_addr_in;
              ram_write_data_out    <= m1_wdata_in;
              ram_write_en_out      <= m1_write_en_in;
              ram_read_en_out       <= ~m1_write_en_in;
              ram_write_byte_en_out <= m1_byte_en_in;
            end else begin
              ram_addr_out          <= m0_addr_in;
              ram_write_data_out    <= '0;
              ram_write_en_out      <= 1'b0;
              ram_read_en_out       <= 1'b1;
              ram_write_byte_en_out <= 4'b0000;
            end
          end
        end

        S_ISSUE: begin
          // Fields stay frozen until the RAM accepts.
          if (ram_ready_in) begin
            ram_valid_out <= 1'b0;
            if (ram_write_en_out) begin
              // Only m1 can write, so a write completion is always m1's.
              m1_done_out <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_state <= S_WAIT_RD;
`ifdef RAM_ARB_TIMEOUT_EN
              r_wait_cnt <= '0;
`endif
            end
          end
        end

        S_WAIT_RD: begin
          if (ram_rdata_valid_in | w_timeout) begin
            r_state <= S_IDLE;
            if (r_owner) begin
              m1_done_out  <= 1'b1;
              m1_rdata_out <= w_fin_data;
            end else begin
              m0_rdata_valid_out <= 1'b1;
              m0_rdata_out       <= w_fin_data;
            end
`ifdef RAM_ARB_TIMEOUT_EN
            r_bus_err <= w_timeout;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
`endif
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter. A transaction-level model
//            predicts every output each cycle; directed tests add literal
//            expectations. The bench also plays the RAM (registered read
//            data one cycle after the handshake, byte-enabled writes).
//            Timeout scenario runs when RAM_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req_in, m1_req_in, m1_write_en_in;
  logic [AW-1:0] m0_addr_in, m1_addr_in;
  logic [DW-1:0] m1_wdata_in;
  logic [3:0]    m1_byte_en_in;
  logic          m0_grant_out, m0_rdata_valid_out, m1_grant_out, m1_done_out, bus_err_out;
  logic [DW-1:0] m0_rdata_out, m1_rdata_out;
  logic [AW-1:0] ram_addr_out;
  logic [DW-1:0] ram_write_data_out;
  logic          ram_read_en_out, ram_write_en_out, ram_valid_out;
  logic [3:0]    ram_write_byte_en_out;
  logic          ram_ready_in, ram_rdata_valid_in;
  logic [DW-1:0] ram_rdata_in;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req_in(m0_req_in), .m0_addr_in(m0_addr_in),
    .m0_grant_out(m0_grant_out), .m0_rdata_valid_out(m0_rdata_valid_out),
    .m0_rdata_out(m0_rdata_out),
    .m1_req_in(m1_req_in), .m1_addr_in(m1_addr_in), .m1_wdata_in(m1_wdata_in),
    .m1_write_en_in(m1_write_en_in), .m1_byte_en_in(m1_byte_en_in),
    .m1_grant_out(m1_grant_out), .m1_done_out(m1_done_out), .m1_rdata_out(m1_rdata_out),
    .bus_err_out(bus_err_out),
    .ram_addr_out(ram_addr_out), .ram_write_data_out(ram_write_data_out),
    .ram_read_en_out(ram_read_en_out), .ram_write_en_out(ram_write_en_out),
    .ram_write_byte_en_out(ram_write_byte_en_out), .ram_valid_out(ram_valid_out),
    .ram_ready_in(ram_ready_in), .ram_rdata_valid_in(ram_rdata_valid_in),
    .ram_rdata_in(ram_rdata_in)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM responder ----------------
  logic [31:0] mem [0:63];
  bit          mute = 1'b0;   // swallow read responses
  int          stray_req = 0; // requested unsolicited rdata_valid pulses
  int          stray_done = 0;

  initial begin
    bit          hs, hs_we;
    logic [31:0] hs_addr, hs_wdata;
    logic [3:0]  hs_be;
    ram_rdata_valid_in = 1'b0;
    ram_rdata_in       = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[4] = 32'hDEAD_BEEF;
    mem[2] = 32'h1122_3344;
    forever begin
      @(negedge clk);
      hs       = rst && ram_valid_out && ram_ready_in;
      hs_we    = ram_write_en_out;
      hs_addr  = ram_addr_out;
      hs_wdata = ram_write_data_out;
      hs_be    = ram_write_byte_en_out;
      @(posedge clk);
      #1;
      ram_rdata_valid_in = 1'b0;
      if (hs) begin
        if (hs_we) begin
          for (int b = 0; b < 4; b++)
            if (hs_be[b]) mem[hs_addr[7:2]][8*b +: 8] = hs_wdata[8*b +: 8];
        end else if (!mute) begin
          ram_rdata_valid_in = 1'b1;
          ram_rdata_in       = mem[hs_addr[7:2]];
        end
      end else if (stray_req != stray_done) begin
        stray_done++;
        ram_rdata_valid_in = 1'b1;
        ram_rdata_in       = 32'hBAD0_BAD0;
      end
    end
  end

  // ---------------- transaction-level model ----------------
  // busy: a transaction is owned; sent: the RAM has accepted it (reads only).
  bit          md_busy, md_sent, md_last_m1, md_m1, md_we, md_pick;
  int          md_waited;
  logic [31:0] e_addr, e_wdata, e_m0_rdata, e_m1_rdata;
  logic [3:0]  e_be;
  bit          e_m0_grant, e_m1_grant, e_m0_rv, e_m1_done, e_err, e_ram_valid, e_re;

  task automatic md_deliver(input logic [31:0] d, input bit err);
    md_busy = 1'b0;
    e_err   = err;
    if (md_m1) begin e_m1_done = 1'b1; e_m1_rdata = d; end
    else       begin e_m0_rv   = 1'b1; e_m0_rdata = d; end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_busy = 0; md_sent = 0; md_last_m1 = 1; md_m1 = 0; md_we = 0; md_waited = 0;
      e_m0_grant = 0; e_m1_grant = 0; e_m0_rv = 0; e_m1_done = 0; e_err = 0;
      e_ram_valid = 0; e_re = 0; e_addr = 0; e_wdata = 0; e_be = 0;
      e_m0_rdata = 0; e_m1_rdata = 0;
    end else begin
      e_m0_grant = 0; e_m1_grant = 0; e_m0_rv = 0; e_m1_done = 0; e_err = 0;
      if (!md_busy) begin
        if (m0_req_in || m1_req_in) begin
          md_pick    = (m0_req_in && m1_req_in) ? !md_last_m1 : m1_req_in;
          md_last_m1 = md_pick;
          md_m1      = md_pick;
          md_busy    = 1; md_sent = 0;
          e_m0_grant = !md_pick; e_m1_grant = md_pick;
          e_ram_valid = 1;
          e_addr  = md_pick ? m1_addr_in : m0_addr_in;
          e_wdata = md_pick ? m1_wdata_in : 32'h0;
          md_we   = md_pick && m1_write_en_in;
          e_re    = !md_we;
          e_be    = md_pick ? m1_byte_en_in : 4'b0000;
        end
      end else if (!md_sent) begin
        if (ram_ready_in) begin
          e_ram_valid = 0;
          if (md_we) begin md_busy = 0; e_m1_done = 1; end
          else begin md_sent = 1; md_waited = 0; end
        end
      end else if (ram_rdata_valid_in) begin
        md_deliver(ram_rdata_in, 1'b0);
      end else begin
        md_waited++;
`ifdef RAM_ARB_TIMEOUT_EN
        if (md_waited == TO) md_deliver(32'h0, 1'b1);
`endif
      end
    end
  end

  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m0_grant", m0_grant_out, e_m0_grant);
      chk("m1_grant", m1_grant_out, e_m1_grant);
      chk("m0_rdata_valid", m0_rdata_valid_out, e_m0_rv);
      chk("m0_rdata", m0_rdata_out, e_m0_rdata);
      chk("m1_done", m1_done_out, e_m1_done);
      chk("m1_rdata", m1_rdata_out, e_m1_rdata);
      chk("bus_err", bus_err_out, e_err);
      chk("ram_valid", ram_valid_out, e_ram_valid);
      if (e_ram_valid) begin
        chk("ram_addr", ram_addr_out, e_addr);
        chk("ram_wdata", ram_write_data_out, e_wdata);
        chk("ram_write_en", ram_write_en_out, md_we);
        chk("ram_read_en", ram_read_en_out, e_re);
        chk("ram_byte_en", ram_write_byte_en_out, e_be);
      end
    end
  end

  // One complete transaction with bounded waits for grant and completion.
  task automatic xfer(input bit m1, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit we, input logic [3:0] be,
                      output logic [31:0] data, output bit err);
    bit seen = 1'b0;
    data = '0; err = 1'b0;
    @(posedge clk); #1;
    if (m1) begin
      m1_req_in = 1; m1_addr_in = addr; m1_wdata_in = wdata;
      m1_write_en_in = we; m1_byte_en_in = be;
    end else begin
      m0_req_in = 1; m0_addr_in = addr;
    end
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = m1 ? m1_grant_out : m0_grant_out;
    end
    chk("xfer grant seen", seen, 1);
    @(posedge clk); #1;
    m0_req_in = 0; m1_req_in = 0; m1_write_en_in = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = m1 ? m1_done_out : m0_rdata_valid_out;
      if (seen) begin
        data = m1 ? m1_rdata_out : m0_rdata_out;
        err  = bus_err_out;
      end
    end
    chk("xfer completion seen", seen, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    bit          e;
    bit          g [$];
    int          n_done;
    m0_req_in = 0; m1_req_in = 0; m1_write_en_in = 0;
    m0_addr_in = 0; m1_addr_in = 0; m1_wdata_in = 0; m1_byte_en_in = 0;
    ram_ready_in = 1;
    #2 rst = 0;
    cmp_on = 1;
    @(negedge clk);
    chk("reset ram_valid", ram_valid_out, 0);
    chk("reset m0_grant", m0_grant_out, 0);
    chk("reset m1_done", m1_done_out, 0);
    chk("reset ram_read_en", ram_read_en_out, 0);
    @(posedge clk); #1 rst = 1;

    // --- m0 read of 0x10 ---
    @(posedge clk); #1; m0_req_in = 1; m0_addr_in = 32'h10;
    @(negedge clk); chk("t1 c0 grant", m0_grant_out, 0);
    @(negedge clk);
    chk("t1 c1 grant", m0_grant_out, 1);
    chk("t1 c1 ram_valid", ram_valid_out, 1);
    chk("t1 c1 ram_addr", ram_addr_out, 32'h10);
    chk("t1 c1 read_en", ram_read_en_out, 1);
    @(posedge clk); #1 m0_req_in = 0;
    @(negedge clk); chk("t1 c2 ram_valid", ram_valid_out, 0);
    @(negedge clk);
    chk("t1 c3 rdata_valid", m0_rdata_valid_out, 1);
    chk("t1 c3 rdata", m0_rdata_out, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1 c4 rdata_valid", m0_rdata_valid_out, 0);
    chk("t1 c4 rdata held", m0_rdata_out, 32'hDEAD_BEEF);

    // --- m1 write 0x55 to 0x8, byte 0 only ---
    @(posedge clk); #1;
    m1_req_in = 1; m1_addr_in = 32'h8; m1_wdata_in = 32'h55;
    m1_write_en_in = 1; m1_byte_en_in = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    chk("t2 c1 grant", m1_grant_out, 1);
    chk("t2 c1 ram_valid", ram_valid_out, 1);
    chk("t2 c1 write_en", ram_write_en_out, 1);
    chk("t2 c1 byte_en", ram_write_byte_en_out, 4'b0001);
    chk("t2 c1 wdata", ram_write_data_out, 32'h55);
    @(posedge clk); #1 m1_req_in = 0; m1_write_en_in = 0;
    @(negedge clk);
    chk("t2 c2 done", m1_done_out, 1);
    chk("t2 c2 m0 quiet", m0_rdata_valid_out, 0);
    xfer(1, 32'h8, 0, 0, 0, d, e);
    chk("t2 readback", d, 32'h1122_3355);

    // --- both masters requesting continuously after reset ---
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    m0_req_in = 1; m0_addr_in = 32'h10; m1_req_in = 1; m1_addr_in = 32'h14;
    m1_write_en_in = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m0_grant_out) g.push_back(1'b0);
      if (m1_grant_out) g.push_back(1'b1);
    end
    @(posedge clk); #1 m0_req_in = 0; m1_req_in = 0;
    chk("t3 grant count", g.size(), 7);
    if (g.size() > 0) chk("t3 first grant m0", g[0], 0);
    for (int i = 1; i < g.size(); i++) chk("t3 alternation", g[i], !g[i-1]);
    repeat (5) @(negedge clk);

    // --- RAM not ready for 5 ISSUE cycles ---
    @(posedge clk); #1; ram_ready_in = 0; m0_req_in = 1; m0_addr_in = 32'h18;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 2) m0_req_in = 0;
      if (c == 6) ram_ready_in = 1;
      @(negedge clk);
      if (c <= 6) begin
        chk("t4 valid held", ram_valid_out, 1);
        chk("t4 addr held", ram_addr_out, 32'h18);
      end
      if (c == 1) chk("t4 grant", m0_grant_out, 1);
      if (c == 7) chk("t4 valid dropped", ram_valid_out, 0);
      chk("t4 rdata_valid", m0_rdata_valid_out, c == 8);
      if (c == 8) chk("t4 rdata", m0_rdata_out, 32'h1000_0006);
    end

    // --- reset while waiting for read data ---
    mute = 1;
    n_done = 0;
    @(posedge clk); #1; m1_req_in = 1; m1_addr_in = 32'h1C; m1_write_en_in = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 2) m1_req_in = 0;
      if (c == 3) begin
        rst = 0;
        #1;
        chk("t5 reset ram_valid", ram_valid_out, 0);
        chk("t5 reset m1_done", m1_done_out, 0);
        chk("t5 reset m0_rdata", m0_rdata_out, 0);
        chk("t5 reset ram_read_en", ram_read_en_out, 0);
      end
      if (c == 5) begin rst = 1; mute = 0; end
      if (c == 6) stray_req++;
      @(negedge clk);
      if (m1_done_out) n_done++;
    end
    chk("t5 no done after reset", n_done, 0);
    xfer(1, 32'h1C, 0, 0, 0, d, e);
    chk("t5 m1 read after reset", d, 32'h1000_0007);
    xfer(0, 32'h10, 0, 0, 0, d, e);
    chk("t5 m0 read after reset", d, 32'hDEAD_BEEF);

`ifdef RAM_ARB_TIMEOUT_EN
    // --- read data never arrives ---
    mute = 1;
    @(posedge clk); #1; m0_req_in = 1; m0_addr_in = 32'h10;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 2) m0_req_in = 0;
      @(negedge clk);
      chk("t6 rdata_valid", m0_rdata_valid_out, c == 6);
      chk("t6 bus_err", bus_err_out, c == 6);
      if (c == 6) chk("t6 rdata zero", m0_rdata_out, 0);
    end
    stray_req++;
    repeat (5) @(negedge clk);
    mute = 0;
    xfer(0, 32'h10, 0, 0, 0, d, e);
    chk("t6 read after timeout", d, 32'hDEAD_BEEF);
    chk("t6 no err after timeout", e, 0);
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
